// File: rtl/scarv_cop_ienc_pkg.sv
// Shared definitions for the SCARV coprocessor instruction encoder/issuer:
// opcode, instruction formats, completion status codes and FSM states.
package scarv_cop_ienc_pkg;

    localparam logic [6:0] SCARV_COP_OPCODE = 7'b0101011;

    typedef enum logic [2:0] {
        SCARV_COP_FMT_R   = 3'd0,
        SCARV_COP_FMT_I8  = 3'd1,
        SCARV_COP_FMT_I10 = 3'd2,
        SCARV_COP_FMT_LD  = 3'd3,
        SCARV_COP_FMT_ST  = 3'd4,
        SCARV_COP_FMT_LI  = 3'd5
    } scarv_cop_fmt_t;

    localparam logic [1:0] SCARV_COP_ISTAT_OK      = 2'd0;
    localparam logic [1:0] SCARV_COP_ISTAT_EXC     = 2'd1;
    localparam logic [1:0] SCARV_COP_ISTAT_ERR     = 2'd2;
    localparam logic [1:0] SCARV_COP_ISTAT_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENC   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } ienc_state_t;

endpackage

// File: rtl/scarv_cop_ienc_pack.sv
// Combinational field packing of a coprocessor instruction word.
// SCARV_COP_IENC_CHECK_EN adds an immediate range check reported through err.
module scarv_cop_ienc_pack
    import scarv_cop_ienc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [7:0]  funct,
    input  logic [2:0]  f3,
    input  logic [3:0]  crd,
    input  logic [3:0]  crs1,
    input  logic [3:0]  crs2,
    input  logic [4:0]  rs1,
    input  logic [31:0] imm,
    output logic [31:0] insn,
    output logic        err
);

    logic fmt_bad;
    logic range_ok;

    always_comb begin
        insn    = {25'd0, SCARV_COP_OPCODE};
        fmt_bad = 1'b0;
        case (fmt)
            SCARV_COP_FMT_R:   insn = {funct, crs2, 1'b0, crs1, f3, 1'b0, crd, SCARV_COP_OPCODE};
            SCARV_COP_FMT_I8:  insn = {imm[7:0], crs2, 1'b0, crs1, f3, 1'b0, crd, SCARV_COP_OPCODE};
            SCARV_COP_FMT_I10: insn = {imm[9:0], funct[1:0], 1'b0, crs1, f3, 1'b0, crd, SCARV_COP_OPCODE};
            SCARV_COP_FMT_LD:  insn = {imm[10:0], funct[0], rs1, f3, 1'b0, crd, SCARV_COP_OPCODE};
            SCARV_COP_FMT_ST:  insn = {imm[10:4], funct[0], crs2, rs1, f3, 1'b0, imm[3:0], SCARV_COP_OPCODE};
            SCARV_COP_FMT_LI:  insn = {imm[15:5], funct[0], imm[4:0], f3, 1'b0, crd, SCARV_COP_OPCODE};
            default:           fmt_bad = 1'b1;
        endcase
    end

`ifdef SCARV_COP_IENC_CHECK_EN
    // LD/ST offsets are signed 11-bit; the others are unsigned field widths.
    always_comb begin
        range_ok = 1'b1;
        case (fmt)
            SCARV_COP_FMT_I8:  range_ok = (imm[31:8] == '0);
            SCARV_COP_FMT_I10: range_ok = (imm[31:10] == '0);
            SCARV_COP_FMT_LD,
            SCARV_COP_FMT_ST:  range_ok = (imm[31:10] == '0) || (imm[31:10] == '1);
            SCARV_COP_FMT_LI:  range_ok = (imm[31:16] == '0);
            default:           range_ok = 1'b1;
        endcase
    end
`else
    logic unused_imm;
    assign range_ok   = 1'b1;
    assign unused_imm = ^imm[31:16];
`endif

    assign err = fmt_bad || !range_ok;

endmodule

// File: rtl/scarv_cop_iencode.sv
// SCARV coprocessor instruction encoder/issuer: capture, encode, issue, wait, report.
// Optional immediate range check enabled by defining SCARV_COP_IENC_CHECK_EN.
module scarv_cop_iencode
    import scarv_cop_ienc_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [7:0]  req_funct,
    input  logic [2:0]  req_f3,
    input  logic [3:0]  req_crd,
    input  logic [3:0]  req_crs1,
    input  logic [3:0]  req_crs2,
    input  logic [4:0]  req_rs1,
    input  logic [31:0] req_imm,
    output logic        cop_insn_valid,
    input  logic        cop_insn_ready,
    output logic [31:0] cop_insn,
    input  logic        cop_rsp_valid,
    input  logic        cop_rsp_exception,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [1:0]  done_status,
    output logic [31:0] done_insn
);

    localparam logic [7:0] TMO = 8'(RSP_TIMEOUT);

    ienc_state_t state;
    logic [2:0]  fmt_q;
    logic [7:0]  funct_q;
    logic [2:0]  f3_q;
    logic [3:0]  crd_q;
    logic [3:0]  crs1_q;
    logic [3:0]  crs2_q;
    logic [4:0]  rs1_q;
    logic [31:0] imm_q;
    logic [7:0]  tmo_cnt;
    logic [31:0] pack_insn;
    logic        pack_err;

    scarv_cop_ienc_pack u_pack (
        .fmt   (fmt_q),
        .funct (funct_q),
        .f3    (f3_q),
        .crd   (crd_q),
        .crs1  (crs1_q),
        .crs2  (crs2_q),
        .rs1   (rs1_q),
        .imm   (imm_q),
        .insn  (pack_insn),
        .err   (pack_err)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            cop_insn_valid <= 1'b0;
            cop_insn       <= '0;
            done_valid     <= 1'b0;
            done_status    <= SCARV_COP_ISTAT_OK;
            done_insn      <= '0;
            fmt_q          <= '0;
            funct_q        <= '0;
            f3_q           <= '0;
            crd_q          <= '0;
            crs1_q         <= '0;
            crs2_q         <= '0;
            rs1_q          <= '0;
            imm_q          <= '0;
            tmo_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        fmt_q     <= req_fmt;
                        funct_q   <= req_funct;
                        f3_q      <= req_f3;
                        crd_q     <= req_crd;
                        crs1_q    <= req_crs1;
                        crs2_q    <= req_crs2;
                        rs1_q     <= req_rs1;
                        imm_q     <= req_imm;
                        req_ready <= 1'b0;
                        state     <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    if (pack_err) begin
                        done_valid  <= 1'b1;
                        done_status <= SCARV_COP_ISTAT_ERR;
                        done_insn   <= pack_insn;
                        state       <= ST_DONE;
                    end else begin
                        cop_insn       <= pack_insn;
                        cop_insn_valid <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cop_insn_ready) begin
                        cop_insn_valid <= 1'b0;
                        tmo_cnt        <= '0;
                        // A response coinciding with acceptance completes immediately.
                        if (cop_rsp_valid) begin
                            done_valid  <= 1'b1;
                            done_status <= cop_rsp_exception ? SCARV_COP_ISTAT_EXC : SCARV_COP_ISTAT_OK;
                            done_insn   <= cop_insn;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cop_rsp_valid) begin
                        done_valid  <= 1'b1;
                        done_status <= cop_rsp_exception ? SCARV_COP_ISTAT_EXC : SCARV_COP_ISTAT_OK;
                        done_insn   <= cop_insn;
                        state       <= ST_DONE;
                    end else if (tmo_cnt + 8'd1 == TMO) begin
                        done_valid  <= 1'b1;
                        done_status <= SCARV_COP_ISTAT_TIMEOUT;
                        done_insn   <= cop_insn;
                        state       <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scarv_cop_iencode.sv
// Self-checking bench for scarv_cop_iencode: table-driven transactions with a
// scoreboard queue, plus hand-written reset-in-WAIT sequence.
module tb_scarv_cop_iencode;

    localparam int RSP_TO = 8;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [7:0]  req_funct;
    logic [2:0]  req_f3;
    logic [3:0]  req_crd;
    logic [3:0]  req_crs1;
    logic [3:0]  req_crs2;
    logic [4:0]  req_rs1;
    logic [31:0] req_imm;
    logic        cop_insn_valid;
    logic        cop_insn_ready;
    logic [31:0] cop_insn;
    logic        cop_rsp_valid;
    logic        cop_rsp_exception;
    logic        done_valid;
    logic        done_ready;
    logic [1:0]  done_status;
    logic [31:0] done_insn;

    always #5 g_clk = ~g_clk;

    scarv_cop_iencode #(.RSP_TIMEOUT(RSP_TO)) dut (
        .g_clk             (g_clk),
        .g_resetn          (g_resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_fmt           (req_fmt),
        .req_funct         (req_funct),
        .req_f3            (req_f3),
        .req_crd           (req_crd),
        .req_crs1          (req_crs1),
        .req_crs2          (req_crs2),
        .req_rs1           (req_rs1),
        .req_imm           (req_imm),
        .cop_insn_valid    (cop_insn_valid),
        .cop_insn_ready    (cop_insn_ready),
        .cop_insn          (cop_insn),
        .cop_rsp_valid     (cop_rsp_valid),
        .cop_rsp_exception (cop_rsp_exception),
        .done_valid        (done_valid),
        .done_ready        (done_ready),
        .done_status       (done_status),
        .done_insn         (done_insn)
    );

    // mode: 0 response with the issue handshake, 1 response dly cycles later, 2 never
    typedef struct {
        logic [2:0]  fmt;
        logic [7:0]  funct;
        logic [2:0]  f3;
        logic [3:0]  crd;
        logic [3:0]  crs1;
        logic [3:0]  crs2;
        logic [4:0]  rs1;
        logic [31:0] imm;
        int          stall;
        int          mode;
        int          dly;
        logic        exc;
        logic [31:0] lit;
    } vec_t;

    typedef struct {
        logic [31:0] insn;
        logic [1:0]  status;
    } exp_t;

    vec_t vecs [12];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_insn(input vec_t v);
        logic [31:0] w;
        w = 32'h0000_002B | (32'(v.f3) << 12);
        case (v.fmt)
            3'd0: w |= (32'(v.funct) << 24) | (32'(v.crs2) << 20) | (32'(v.crs1) << 15) | (32'(v.crd) << 7);
            3'd1: w |= ((v.imm & 32'hFF) << 24) | (32'(v.crs2) << 20) | (32'(v.crs1) << 15) | (32'(v.crd) << 7);
            3'd2: w |= ((v.imm & 32'h3FF) << 22) | (32'(v.funct & 8'h03) << 20) | (32'(v.crs1) << 15) | (32'(v.crd) << 7);
            3'd3: w |= ((v.imm & 32'h7FF) << 21) | (32'(v.funct[0]) << 20) | (32'(v.rs1) << 15) | (32'(v.crd) << 7);
            3'd4: w |= (((v.imm >> 4) & 32'h7F) << 25) | (32'(v.funct[0]) << 24) | (32'(v.crs2) << 20)
                       | (32'(v.rs1) << 15) | ((v.imm & 32'hF) << 7);
            3'd5: w |= (((v.imm >> 5) & 32'h7FF) << 21) | (32'(v.funct[0]) << 20) | ((v.imm & 32'h1F) << 15)
                       | (32'(v.crd) << 7);
            default: w = 32'h0000_002B;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] model_status(input vec_t v);
        logic bad;
        bad = (v.fmt > 3'd5);
`ifdef SCARV_COP_IENC_CHECK_EN
        case (v.fmt)
            3'd1:       bad = v.imm > 32'd255;
            3'd2:       bad = v.imm > 32'd1023;
            3'd3, 3'd4: bad = ($signed(v.imm) < -1024) || ($signed(v.imm) > 1023);
            3'd5:       bad = v.imm > 32'd65535;
            default:    ;
        endcase
`endif
        if (bad) return 2'd2;
        if (v.mode == 2) return 2'd3;
        return v.exc ? 2'd1 : 2'd0;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        int          n;
        bit          saw;
        bit          stable;
        logic [31:0] held;
        e.insn   = model_insn(v);
        e.status = model_status(v);
        exp_q.push_back(e);

        @(negedge g_clk);
        req_valid = 1'b1;
        req_fmt   = v.fmt;   req_funct = v.funct; req_f3  = v.f3;
        req_crd   = v.crd;   req_crs1  = v.crs1;  req_crs2 = v.crs2;
        req_rs1   = v.rs1;   req_imm   = v.imm;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge g_clk); n++; end
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        @(negedge g_clk);
        req_valid = 1'b0;

        if (e.status == 2'd2) begin
            saw = 1'b0;
            n = 0;
            while (!done_valid && n < 20) begin
                if (cop_insn_valid) saw = 1'b1;
                @(negedge g_clk); n++;
            end
            chk($sformatf("v%0d no_issue", idx), 32'(saw), 32'd0);
        end else begin
            n = 0;
            while (!cop_insn_valid && n < 20) begin @(negedge g_clk); n++; end
            chk($sformatf("v%0d issue_valid", idx), 32'(cop_insn_valid), 32'd1);
            chk($sformatf("v%0d cop_insn", idx), cop_insn, e.insn);
            if (v.lit != 32'd0) chk($sformatf("v%0d cop_insn_literal", idx), cop_insn, v.lit);
            held   = cop_insn;
            stable = 1'b1;
            for (int i = 0; i < v.stall; i++) begin
                @(negedge g_clk);
                if (!cop_insn_valid || cop_insn !== held) stable = 1'b0;
            end
            if (v.stall > 0) chk($sformatf("v%0d stall_stable", idx), 32'(stable), 32'd1);
            cop_insn_ready = 1'b1;
            if (v.mode == 0) begin cop_rsp_valid = 1'b1; cop_rsp_exception = v.exc; end
            @(negedge g_clk);
            cop_insn_ready = 1'b0; cop_rsp_valid = 1'b0; cop_rsp_exception = 1'b0;
            if (v.mode == 1) begin
                repeat (v.dly) @(negedge g_clk);
                cop_rsp_valid = 1'b1; cop_rsp_exception = v.exc;
                @(negedge g_clk);
                cop_rsp_valid = 1'b0; cop_rsp_exception = 1'b0;
            end else if (v.mode == 2) begin
                n = 0;
                while (!done_valid && n < 300) begin @(negedge g_clk); n++; end
                chk($sformatf("v%0d timeout_cycles", idx), 32'(n), 32'(RSP_TO));
            end
        end

        n = 0;
        while (!done_valid && n < 300) begin @(negedge g_clk); n++; end
        chk($sformatf("v%0d done_valid", idx), 32'(done_valid), 32'd1);
        // A stray response while the result is pending must not disturb it.
        cop_rsp_valid = 1'b1; cop_rsp_exception = 1'b1;
        @(negedge g_clk);
        cop_rsp_valid = 1'b0; cop_rsp_exception = 1'b0;
        chk($sformatf("v%0d done_held", idx), 32'(done_valid), 32'd1);
        e = exp_q.pop_front();
        chk($sformatf("v%0d done_status", idx), 32'(done_status), 32'(e.status));
        chk($sformatf("v%0d done_insn", idx), done_insn, e.insn);
        done_ready = 1'b1;
        @(negedge g_clk);
        done_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " cop_insn_valid"}, 32'(cop_insn_valid), 32'd0);
        chk({tag, " cop_insn"}, cop_insn, 32'd0);
        chk({tag, " done_valid"}, 32'(done_valid), 32'd0);
        chk({tag, " done_status"}, 32'(done_status), 32'd0);
        chk({tag, " done_insn"}, done_insn, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit saw;
        //           fmt   funct  f3    crd   crs1  crs2  rs1    imm           stl md dly exc   lit
        vecs[0]  = '{3'd3, 8'h00, 3'd0, 4'd5, 4'd0, 4'd0, 5'd10, 32'hFFFFFFFC, 0, 1, 0, 1'b0, 32'hFF8502AB};
        vecs[1]  = '{3'd3, 8'h00, 3'd0, 4'd5, 4'd0, 4'd0, 5'd10, 32'hFFFFFFFC, 5, 1, 0, 1'b0, 32'hFF8502AB};
        vecs[2]  = '{3'd1, 8'h00, 3'd1, 4'd2, 4'd4, 4'd6, 5'd0,  32'd256,      0, 1, 0, 1'b0, 32'd0};
        vecs[3]  = '{3'd0, 8'h3C, 3'd2, 4'd3, 4'd1, 4'd2, 5'd0,  32'd0,        0, 2, 0, 1'b0, 32'd0};
        vecs[4]  = '{3'd2, 8'h02, 3'd3, 4'd9, 4'd3, 4'd0, 5'd0,  32'd1000,     1, 1, 2, 1'b1, 32'd0};
        vecs[5]  = '{3'd0, 8'hA5, 3'd5, 4'd1, 4'd2, 4'd3, 5'd0,  32'd0,        0, 0, 0, 1'b0, 32'd0};
        vecs[6]  = '{3'd4, 8'h01, 3'd6, 4'd0, 4'd0, 4'd7, 5'd31, 32'hFFFFFC00, 0, 1, 1, 1'b0, 32'd0};
        vecs[7]  = '{3'd5, 8'h01, 3'd7, 4'd15,4'd0, 4'd0, 5'd0,  32'h0000FFFF, 0, 1, 0, 1'b0, 32'd0};
        vecs[8]  = '{3'd6, 8'hFF, 3'd7, 4'd15,4'd15,4'd15,5'd31, 32'h12345678, 0, 1, 0, 1'b0, 32'd0};
        vecs[9]  = '{3'd7, 8'h11, 3'd1, 4'd1, 4'd1, 4'd1, 5'd1,  32'd1,        0, 1, 0, 1'b0, 32'd0};
        vecs[10] = '{3'd3, 8'h01, 3'd4, 4'd6, 4'd0, 4'd0, 5'd3,  32'd1024,     0, 1, 0, 1'b1, 32'd0};
        vecs[11] = '{3'd1, 8'h00, 3'd0, 4'd7, 4'd8, 4'd9, 5'd0,  32'd255,      0, 0, 0, 1'b1, 32'd0};

        g_resetn = 1'b0;
        req_valid = 1'b0; req_fmt = '0; req_funct = '0; req_f3 = '0; req_crd = '0;
        req_crs1 = '0; req_crs2 = '0; req_rs1 = '0; req_imm = '0;
        cop_insn_ready = 1'b0; cop_rsp_valid = 1'b0; cop_rsp_exception = 1'b0; done_ready = 1'b0;
        repeat (3) @(negedge g_clk);
        chk_reset_outputs("por");
        g_resetn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Reset asserted while waiting for a response.
        @(negedge g_clk);
        req_valid = 1'b1; req_fmt = 3'd3; req_funct = 8'h00; req_f3 = 3'd0; req_crd = 4'd5;
        req_rs1 = 5'd10; req_imm = 32'hFFFFFFFC;
        @(negedge g_clk);
        req_valid = 1'b0;
        n = 0;
        while (!cop_insn_valid && n < 20) begin @(negedge g_clk); n++; end
        chk("rst issue_valid", 32'(cop_insn_valid), 32'd1);
        cop_insn_ready = 1'b1;
        @(negedge g_clk);
        cop_insn_ready = 1'b0;
        @(negedge g_clk);
        #2 g_resetn = 1'b0;
        #1 chk_reset_outputs("rst_wait");
        @(negedge g_clk);
        g_resetn = 1'b1;
        saw = 1'b0;
        repeat (RSP_TO + 4) begin
            @(negedge g_clk);
            if (done_valid || cop_insn_valid) saw = 1'b1;
        end
        chk("rst no_done", 32'(saw), 32'd0);
        run_vec(vecs[0], 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scarv_cop_iencode.md
# scarv_cop_iencode

Instruction encoder and issuer for the SCARV ISE coprocessor, the producer side of the 32-bit coprocessor instruction word. It accepts a field-level instruction request (format, function bits, register addresses, immediate) and packs it into a 32-bit encoding. It issues that word to the coprocessor over a valid/ready handshake, waits for the completion response, and reports a status. It sits between a host/sequencer master and the coprocessor instruction port.

## Interface
- RSP_TIMEOUT, 255: maximum cycles to wait for a coprocessor response, counted from instruction acceptance; range 1..255.
- g_clk  in  1  clock, rising edge.
- g_resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_fmt  in  3  format: 0 R, 1 I8, 2 I10, 3 LD, 4 ST, 5 LI; 6–7 are illegal.
- req_funct  in  8  format-specific function bits.
- req_f3  in  3  funct3.
- req_crd, req_crs1, req_crs2  in  4 each  coprocessor register addresses.
- req_rs1  in  5  GPR address.
- req_imm  in  32  immediate, two's complement.
- cop_insn_valid  out  1  encoded word valid.
- cop_insn_ready  in  1  coprocessor accepts word.
- cop_insn  out  32  encoded instruction.
- cop_rsp_valid  in  1  single-cycle completion pulse.
- cop_rsp_exception  in  1  coprocessor raised an illegal-instruction exception.
- done_valid  out  1  result valid.
- done_ready  in  1  result consumed.
- done_status  out  2  status: 0 OK, 1 exception, 2 range/format error, 3 timeout.
- done_insn  out  32  the encoding that was built.

## Operation
- Every encoding has opcode[6:0] = SCARV_COP_OPCODE (7'b0101011) and funct3 at [14:12].
- R: [31:24] funct, [23:20] crs2, [19] 0, [18:15] crs1, [11] 0, [10:7] crd.
- I8: [31:24] imm[7:0]; the rest is as for R.
- I10: [31:22] imm[9:0], [21:20] funct[1:0], [19] 0, [18:15] crs1, [10:7] crd.
- LD: [31:21] imm[10:0], [20] funct[0], [19:15] rs1, [11] 0, [10:7] crd.
- ST: [31:25] imm[10:4], [24] funct[0], [23:20] crs2, [19:15] rs1, [11] 0, [10:7] imm[3:0].
- LI: [31:21] imm[15:5], [20] funct[0], [19:15] imm[4:0], [11] 0, [10:7] crd.
- FSM states:
  - IDLE: req_ready=1. A handshake captures all request fields; go to ENC.
  - ENC: register the encoding and the check result. An error goes to DONE with status 2; otherwise go to ISSUE.
  - ISSUE: cop_insn_valid=1 with cop_insn held stable until cop_insn_ready.
    - On the handshake, a cop_rsp_valid in the same cycle goes directly to DONE.
    - Otherwise go to WAIT and clear the timeout counter.
  - WAIT: cop_rsp_valid goes to DONE with status = cop_rsp_exception ? 1 : 0. The counter increments each cycle; when it reaches RSP_TIMEOUT, go to DONE with status 3.
  - DONE: done_valid=1, outputs held until done_ready, then go to IDLE.
- cop_rsp_valid is ignored in IDLE, ENC and DONE, and in ISSUE without the handshake.
- Illegal req_fmt (6–7) always gives status 2, with the encoding all-zero except the opcode.
- Asynchronous reset in any state:
  - Returns the FSM to IDLE.
  - Drops any in-flight instruction with no done report.
  - Resets outputs to: req_ready=1, cop_insn_valid=0, cop_insn=0, done_valid=0, done_status=0, done_insn=0.

## Timing
- Request accepted in cycle N; ENC in N+1; cop_insn_valid from N+2.
- With ready=1 and the response in N+2, done_valid is at N+3.
- One instruction in flight; no pipelining. Throughput is at best one instruction per 4 cycles.
- done_valid and done_insn come from registers. cop_insn comes from a register and is stable across ISSUE.

## Configuration
- SCARV_COP_IENC_CHECK_EN defined: in ENC, check the immediate range and raise a range error (status 2, no issue) if it fails.
  - LD/ST: -1024..1023.
  - I8: 0..255.
  - I10: 0..1023.
  - LI: 0..65535.
  - R: no check.
- Not defined: immediates are silently truncated to the field width and always issued; status 2 arises only for an illegal format.

## Structure
- Shared package scarv_cop_ienc_pkg holds:
  - SCARV_COP_OPCODE.
  - The format enumeration (SCARV_COP_FMT_*).
  - The status codes (SCARV_COP_ISTAT_*).
  - The FSM state typedef.
- Sub-module scarv_cop_ienc_pack: purely combinational field packing plus the range check. The top level holds the FSM, capture registers and timeout counter.

## Test plan
- LD, f3=0, crd=5, rs1=10, imm=-4, funct=0, ready=1, response next cycle with exception=0 → cop_insn=0xFF8502AB and status 0.
- Same request with cop_insn_ready low for 5 cycles → cop_insn stays stable and valid; the response after the handshake gives status 0.
- I8, imm=256, CHECK_EN on → no cop_insn_valid and status 2. CHECK_EN off → issued with imm field 0x00.
- Response never arrives, RSP_TIMEOUT=8 → status 3 eight cycles after the handshake; a response arriving later is ignored.
- Response with cop_rsp_exception=1 → status 1, and done_insn equals the issued word.
- g_resetn asserted in WAIT → all outputs reset immediately, no done_valid, and the next request completes normally.
